// File: rtl/gbe_sched_pkg.sv
// Shared types and constants for the GbE TX stream scheduler.
package gbe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    localparam int MAX_WORDS_DEF = 1024;
    localparam int IP_W          = 32;
    localparam int PORT_W        = 16;

    // Round-robin start index that follows a grant to stream idx.
    function automatic int rr_next(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Scan the request vector starting at ptr and wrapping; keep the first hit.
    always_comb begin
        logic          found_s;
        logic [IW-1:0] pos_s;
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = IW'((int'(ptr) + k) % N);
            if (!found_s && req[pos_s]) begin
                found_s    = 1'b1;
                gnt[pos_s] = 1'b1;
                idx        = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/gbe_tx_sched.sv
// Schedules whole frames from NUM_SRC streams onto one GbE TX port,
// round-robin per frame, with oversize truncation and stall handling.
module gbe_tx_sched
    import gbe_sched_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic                        user_clk,
    input  logic                        user_rst_n,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_eof,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC-1:0]          cfg_enable,
    input  logic [NUM_SRC*IP_W-1:0]     cfg_dest_ip,
    input  logic [NUM_SRC*PORT_W-1:0]   cfg_dest_port,
    input  logic                        tx_afull,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_end_of_frame,
    output logic [IP_W-1:0]             tx_dest_ip,
    output logic [PORT_W-1:0]           tx_dest_port,
    output logic [31:0]                 frame_cnt,
    output logic                        err_oversize,
    output logic [$clog2(NUM_SRC)-1:0]  cur_src
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

    sched_state_t       state_r;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   word_cnt_r;

    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic [NUM_SRC-1:0] grant_oh_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic [IP_W-1:0]    lat_ip_s;
    logic [PORT_W-1:0]  lat_port_s;
    logic               sel_eof_s;
    logic               rdy_s;
    logic               xfer_s;
    logic               last_word_s;

    assign req_s   = src_valid & cfg_enable;
    assign cur_src = grant_r;

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req (req_s),
        .ptr (ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s)
    );

    // Ready for the granted stream only: stalls on afull in XFER, always open in DROP.
    always_comb begin
        rdy_s = 1'b0;
        case (state_r)
            ST_XFER: rdy_s = ~tx_afull;
            ST_DROP: rdy_s = 1'b1;
            default: rdy_s = 1'b0;
        endcase
    end

    // One-hot AND-OR muxes: granted stream data/eof, and destination of the new winner.
    always_comb begin
        grant_oh_s = ONE_HOT0 << grant_r;
        sel_data_s = '0;
        lat_ip_s   = '0;
        lat_port_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_data_s = sel_data_s | (src_data[i*DATA_W +: DATA_W] & {DATA_W{grant_oh_s[i]}});
            lat_ip_s   = lat_ip_s   | (cfg_dest_ip[i*IP_W +: IP_W] & {IP_W{arb_gnt_s[i]}});
            lat_port_s = lat_port_s | (cfg_dest_port[i*PORT_W +: PORT_W] & {PORT_W{arb_gnt_s[i]}});
        end
        sel_eof_s   = |(src_eof & grant_oh_s);
        src_ready   = grant_oh_s & {NUM_SRC{rdy_s}};
        xfer_s      = |(src_valid & src_ready);
        last_word_s = (word_cnt_r == CNT_W'(MAX_WORDS - 1));
    end

    // Frame scheduler FSM with registered TX outputs and status counters.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_r         <= ST_IDLE;
            grant_r         <= '0;
            ptr_r           <= '0;
            word_cnt_r      <= '0;
            tx_valid        <= 1'b0;
            tx_data         <= '0;
            tx_end_of_frame <= 1'b0;
            tx_dest_ip      <= '0;
            tx_dest_port    <= '0;
            frame_cnt       <= 32'd0;
            err_oversize    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_valid        <= 1'b0;
                    tx_end_of_frame <= 1'b0;
                    if (|arb_gnt_s) begin
                        grant_r      <= arb_idx_s;
                        ptr_r        <= IDX_W'(rr_next(int'(arb_idx_s), NUM_SRC));
                        tx_dest_ip   <= lat_ip_s;
                        tx_dest_port <= lat_port_s;
                        word_cnt_r   <= '0;
                        state_r      <= ST_XFER;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    tx_valid <= xfer_s;
                    if (xfer_s) begin
                        tx_data    <= sel_data_s;
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                        if (sel_eof_s) begin
                            tx_end_of_frame <= 1'b1;
                            frame_cnt       <= frame_cnt + 32'd1;
                            state_r         <= ST_GAP;
                        end else if (last_word_s) begin
                            // Truncate: close the frame downstream, swallow the rest.
                            tx_end_of_frame <= 1'b1;
                            err_oversize    <= 1'b1;
                            frame_cnt       <= frame_cnt + 32'd1;
                            state_r         <= ST_DROP;
                        end else begin
                            tx_end_of_frame <= 1'b0;
                        end
                    end else begin
                        tx_end_of_frame <= 1'b0;
                    end
                end
                ST_DROP: begin
                    tx_valid        <= 1'b0;
                    tx_end_of_frame <= 1'b0;
                    if (xfer_s && sel_eof_s) begin
                        state_r <= ST_GAP;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    tx_valid        <= 1'b0;
                    tx_end_of_frame <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbe_tx_sched.sv
// Randomized self-checking bench for gbe_tx_sched against a frame-level model.
module tb_gbe_tx_sched;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int MW = 8;

    typedef struct packed { logic [63:0] data; logic eof; } word_t;
    typedef struct packed { logic [63:0] data; logic eof; logic [31:0] ip; logic [15:0] port; logic [1:0] src; } out_t;

    logic              user_clk = 1'b0;
    logic              user_rst_n;
    logic [NS-1:0]     src_valid, src_eof, src_ready, cfg_enable;
    logic [NS*DW-1:0]  src_data;
    logic [NS*32-1:0]  cfg_dest_ip;
    logic [NS*16-1:0]  cfg_dest_port;
    logic              tx_afull, tx_valid, tx_end_of_frame, err_oversize;
    logic [DW-1:0]     tx_data;
    logic [31:0]       tx_dest_ip, frame_cnt;
    logic [15:0]       tx_dest_port;
    logic [1:0]        cur_src;

    word_t       srcq[NS][$];
    out_t        obs[$];
    out_t        exp_q[$];
    logic [31:0] m_ip[NS];
    logic [15:0] m_port[NS];
    int          m_ptr;
    logic [31:0] m_frames;
    logic        m_err;
    int          fid;
    int          total = 0;
    int          bad   = 0;

    always #5 user_clk = ~user_clk;

    gbe_tx_sched #(.NUM_SRC(NS), .DATA_W(DW), .MAX_WORDS(MW)) dut (
        .user_clk(user_clk), .user_rst_n(user_rst_n),
        .src_valid(src_valid), .src_data(src_data), .src_eof(src_eof), .src_ready(src_ready),
        .cfg_enable(cfg_enable), .cfg_dest_ip(cfg_dest_ip), .cfg_dest_port(cfg_dest_port),
        .tx_afull(tx_afull), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_end_of_frame(tx_end_of_frame), .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
        .frame_cnt(frame_cnt), .err_oversize(err_oversize), .cur_src(cur_src)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic add_frame(input int s, input int len);
        word_t x;
        for (int w = 0; w < len; w++) begin
            x.data = {8'(s), 8'(fid), 16'(w), $urandom()};
            x.eof  = (w == len - 1);
            srcq[s].push_back(x);
        end
        fid++;
    endtask

    // Frame-level reference: round-robin over enabled streams holding frames,
    // each frame truncated to MW words with the last kept word marked eof.
    task automatic build_exp(input logic [NS-1:0] en);
        word_t cp[NS][$];
        word_t w;
        int    found;
        int    n;
        exp_q.delete();
        for (int i = 0; i < NS; i++) cp[i] = srcq[i];
        for (int f = 0; f < 64; f++) begin
            found = -1;
            for (int k = 0; k < NS; k++)
                if (found < 0 && en[(m_ptr + k) % NS] && cp[(m_ptr + k) % NS].size() > 0)
                    found = (m_ptr + k) % NS;
            if (found < 0) break;
            n = 0;
            do begin
                w = cp[found].pop_front();
                n++;
                if (n <= MW)
                    exp_q.push_back('{w.data, (w.eof || n == MW), m_ip[found], m_port[found], 2'(found)});
            end while (!w.eof && cp[found].size() > 0);
            if (n > MW) m_err = 1'b1;
            m_frames = m_frames + 32'd1;
            m_ptr = (found + 1) % NS;
        end
    endtask

    function automatic bit pending(input logic [NS-1:0] mask);
        for (int i = 0; i < NS; i++)
            if (mask[i] && srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: present queue heads, note handshakes, sample outputs after the edge.
    task automatic step();
        logic [NS-1:0] acc;
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = (srcq[i].size() > 0);
            src_eof[i]   = 1'b0;
            src_data[i*DW +: DW] = '0;
            if (srcq[i].size() > 0) begin
                src_eof[i]           = srcq[i][0].eof;
                src_data[i*DW +: DW] = srcq[i][0].data;
            end
        end
        #1;
        acc = src_valid & src_ready;
        total++;
        if ($countones(src_ready) > 1) begin
            bad++;
            $display("FAIL ready_onehot got=%b want=at_most_one", src_ready);
        end
        @(posedge user_clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (acc[i]) void'(srcq[i].pop_front());
        if (tx_valid === 1'b1)
            obs.push_back('{tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port, cur_src});
        @(negedge user_clk);
    endtask

    task automatic run_done(input int budget, input logic [NS-1:0] mask, input bit rnd);
        int n = 0;
        while (pending(mask) && n < budget) begin
            if (rnd) tx_afull = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        tx_afull = 1'b0;
        total++;
        if (pending(mask)) begin
            bad++;
            $display("FAIL drain_timeout got=pending want=drained after %0d cycles", n);
        end
        repeat (4) step();
    endtask

    task automatic wait_obs(input int cnt, input int budget);
        int n = 0;
        while (obs.size() < cnt && n < budget) begin
            step();
            n++;
        end
        total++;
        if (obs.size() < cnt) begin
            bad++;
            $display("FAIL wait_output got=%0d want=%0d words", obs.size(), cnt);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NS; i++) srcq[i].delete();
        user_rst_n = 1'b0;
        repeat (2) step();
        user_rst_n = 1'b1;
        m_ptr = 0; m_frames = 32'd0; m_err = 1'b0;
        total += 9;
        if (tx_valid !== 1'b0)        begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
        if (tx_end_of_frame !== 1'b0) begin bad++; $display("FAIL rst_eof got=%b want=0", tx_end_of_frame); end
        if (tx_data !== 64'd0)        begin bad++; $display("FAIL rst_data got=%h want=0", tx_data); end
        if (tx_dest_ip !== 32'd0)     begin bad++; $display("FAIL rst_ip got=%h want=0", tx_dest_ip); end
        if (tx_dest_port !== 16'd0)   begin bad++; $display("FAIL rst_port got=%h want=0", tx_dest_port); end
        if (frame_cnt !== 32'd0)      begin bad++; $display("FAIL rst_frame_cnt got=%h want=0", frame_cnt); end
        if (err_oversize !== 1'b0)    begin bad++; $display("FAIL rst_err got=%b want=0", err_oversize); end
        if (cur_src !== 2'd0)         begin bad++; $display("FAIL rst_cur_src got=%0d want=0", cur_src); end
        if (src_ready !== 4'd0)       begin bad++; $display("FAIL rst_ready got=%b want=0000", src_ready); end
    endtask

    task automatic test_alternate();
        cfg_enable = 4'b1111;
        obs.delete();
        add_frame(0, 3); add_frame(0, 3); add_frame(2, 3); add_frame(2, 3);
        build_exp(cfg_enable);
        run_done(200, 4'b1111, 1'b0);
        total++;
        if (obs.size() != exp_q.size()) begin bad++; $display("FAIL alt_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL alt_word%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
        total += 2;
        if (frame_cnt !== 32'd4) begin bad++; $display("FAIL alt_frame_cnt got=%0d want=4", frame_cnt); end
        if (obs.size() == 12 && (obs[0].ip !== 32'h0A00_0032 || obs[3].ip !== 32'h0A00_0034)) begin
            bad++; $display("FAIL alt_ip got=%h,%h want=0a000032,0a000034", obs[0].ip, obs[3].ip);
        end
    endtask

    task automatic test_afull();
        obs.delete();
        add_frame(1, 3);
        build_exp(cfg_enable);
        wait_obs(1, 20);
        tx_afull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (tx_valid !== 1'b0) begin bad++; $display("FAIL afull_stall%0d got=%b want=0", c, tx_valid); end
        end
        tx_afull = 1'b0;
        run_done(50, 4'b1111, 1'b0);
        total++;
        if (obs.size() != exp_q.size()) begin bad++; $display("FAIL afull_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL afull_word%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_enable();
        cfg_enable = 4'b0011;
        obs.delete();
        add_frame(0, 4); add_frame(0, 2); add_frame(1, 3); add_frame(1, 2);
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{srcq[0][i].data, srcq[0][i].eof, m_ip[0], m_port[0], 2'd0});
        for (int i = 0; i < srcq[1].size(); i++)
            exp_q.push_back('{srcq[1][i].data, srcq[1][i].eof, m_ip[1], m_port[1], 2'd1});
        m_frames = m_frames + 32'd3;
        m_ptr = 2;
        wait_obs(1, 20);
        cfg_enable[0] = 1'b0;
        run_done(100, 4'b0010, 1'b0);
        total += 2;
        if (obs.size() != exp_q.size()) begin bad++; $display("FAIL en_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        if (srcq[0].size() != 2) begin bad++; $display("FAIL en_s0_left got=%0d want=2", srcq[0].size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL en_word%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
        srcq[0].delete();
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            cfg_enable = 4'($urandom_range(1, 15));
            obs.delete();
            for (int f = 0; f < 5; f++) add_frame($urandom_range(0, NS - 1), $urandom_range(1, 10));
            build_exp(cfg_enable);
            run_done(2000, cfg_enable, 1'b1);
            total += 3;
            if (obs.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, obs.size(), exp_q.size()); end
            if (frame_cnt !== m_frames) begin bad++; $display("FAIL rnd%0d_frame_cnt got=%0d want=%0d", r, frame_cnt, m_frames); end
            if (err_oversize !== m_err) begin bad++; $display("FAIL rnd%0d_err got=%b want=%b", r, err_oversize, m_err); end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                total++;
                if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_word%0d got=%h want=%h", r, i, obs[i], exp_q[i]); end
            end
            for (int i = 0; i < NS; i++) srcq[i].delete();
        end
    endtask

    task automatic test_wrap();
        cfg_enable = 4'b1111;
        force dut.frame_cnt = 32'hFFFF_FFFF;
        step();
        release dut.frame_cnt;
        add_frame(3, 2);
        run_done(50, 4'b1111, 1'b0);
        total++;
        if (frame_cnt !== 32'h0000_0000) begin bad++; $display("FAIL wrap_frame_cnt got=%h want=00000000", frame_cnt); end
    endtask

    task automatic test_oversize();
        user_rst_n = 1'b0;
        step();
        user_rst_n = 1'b1;
        m_ptr = 0; m_frames = 32'd0; m_err = 1'b0;
        cfg_enable = 4'b1111;
        obs.delete();
        add_frame(1, 12);
        build_exp(cfg_enable);
        run_done(100, 4'b1111, 1'b0);
        total += 4;
        if (obs.size() != 8) begin bad++; $display("FAIL ovs_count got=%0d want=8", obs.size()); end
        if (err_oversize !== 1'b1) begin bad++; $display("FAIL ovs_err got=%b want=1", err_oversize); end
        if (frame_cnt !== 32'd1) begin bad++; $display("FAIL ovs_frame_cnt got=%0d want=1", frame_cnt); end
        if (srcq[1].size() != 0) begin bad++; $display("FAIL ovs_consumed got=%0d want=0 left", srcq[1].size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL ovs_word%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
        add_frame(2, 2);
        run_done(50, 4'b1111, 1'b0);
        total++;
        if (err_oversize !== 1'b1) begin bad++; $display("FAIL ovs_sticky got=%b want=1", err_oversize); end
    endtask

    task automatic test_midreset();
        cfg_enable = 4'b1111;
        obs.delete();
        add_frame(1, 6);
        wait_obs(2, 30);
        for (int i = 0; i < NS; i++) srcq[i].delete();
        user_rst_n = 1'b0;
        step();
        user_rst_n = 1'b1;
        m_ptr = 0; m_frames = 32'd0; m_err = 1'b0;
        total += 8;
        if (tx_valid !== 1'b0 || tx_end_of_frame !== 1'b0) begin bad++; $display("FAIL mrst_valid_eof got=%b%b want=00", tx_valid, tx_end_of_frame); end
        if (tx_data !== 64'd0)     begin bad++; $display("FAIL mrst_data got=%h want=0", tx_data); end
        if (tx_dest_ip !== 32'd0)  begin bad++; $display("FAIL mrst_ip got=%h want=0", tx_dest_ip); end
        if (tx_dest_port !== 16'd0) begin bad++; $display("FAIL mrst_port got=%h want=0", tx_dest_port); end
        if (frame_cnt !== 32'd0)   begin bad++; $display("FAIL mrst_frame_cnt got=%0d want=0", frame_cnt); end
        if (err_oversize !== 1'b0) begin bad++; $display("FAIL mrst_err got=%b want=0", err_oversize); end
        if (cur_src !== 2'd0)      begin bad++; $display("FAIL mrst_cur_src got=%0d want=0", cur_src); end
        if (src_ready !== 4'd0)    begin bad++; $display("FAIL mrst_ready got=%b want=0000", src_ready); end
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i].eof !== 1'b0) begin bad++; $display("FAIL mrst_no_eof%0d got=1 want=0", i); end
        end
        obs.delete();
        add_frame(2, 2); add_frame(0, 2);
        build_exp(cfg_enable);
        run_done(50, 4'b1111, 1'b0);
        total++;
        if (obs.size() != exp_q.size()) begin bad++; $display("FAIL mrst_count got=%0d want=%0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL mrst_word%0d got=%h want=%h", i, obs[i], exp_q[i]); end
        end
        total++;
        if (obs.size() > 0 && obs[0].src !== 2'd0) begin bad++; $display("FAIL mrst_first_src got=%0d want=0", obs[0].src); end
    endtask

    initial begin
        user_rst_n = 1'b0;
        tx_afull   = 1'b0;
        cfg_enable = '0;
        src_valid  = '0;
        src_eof    = '0;
        src_data   = '0;
        fid        = 0;
        for (int i = 0; i < NS; i++) begin
            m_ip[i]   = 32'h0A00_0032 + 32'(i);
            m_port[i] = 16'd5000 + 16'(i);
            cfg_dest_ip[i*32 +: 32]   = m_ip[i];
            cfg_dest_port[i*16 +: 16] = m_port[i];
        end
        @(negedge user_clk);
        test_reset();
        test_alternate();
        test_afull();
        test_enable();
        test_random();
        test_wrap();
        test_oversize();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
